seq_array_mult: RTL and testbench
=================================

// Module: seq_array_mult
// PURPOSE
//  Iterative unsigned array multiplier: accepts one WIDTH x WIDTH operand pair,
//  accumulates one partial-product row per cycle, returns a 2*WIDTH product.
//  The accumulator row is built from the existing ha/fa cells.
//  Optional approximate mode truncates the low APPROX_COLS columns of every
//  partial product. Sits beside the combinational array/log multipliers as the
//  area-lean, handshaked variant used in error-vs-area comparisons.
// PARAMETERS
//  WIDTH        8  operand width in bits (>=2); product is 2*WIDTH bits
//  APPROX_COLS  4  low columns zeroed per partial product in approx mode (0..WIDTH)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        block can accept operands
//  a          in   WIDTH    multiplicand (unsigned)
//  b          in   WIDTH    multiplier (unsigned)
//  approx_en  in   1        1 = approximate (truncated) mode for this operation
//  out_valid  out  1        product valid
//  out_ready  in   1        consumer accepts product
//  product    out  2*WIDTH  result
//  busy       out  1        operation in progress (state != IDLE)
// BEHAVIOUR
//  Reset: async on rst=1; state=IDLE, in_ready=1, out_valid=0, busy=0,
//   product=0, accumulator=0, row counter=0. Reset mid-RUN/DONE aborts;
//   no product is emitted.
//  FSM: IDLE -> RUN on accept (in_valid & in_ready); RUN -> DONE after row WIDTH-1;
//   DONE -> IDLE on out_valid & out_ready. No other transitions.
//  in_ready=1 only in IDLE; out_valid=1 only in DONE; busy=1 in RUN and DONE.
//  Accept edge: latch a, b, approx_en; clear accumulator; row counter i=0.
//   Inputs changing after accept have no effect on the current operation.
//  RUN: each cycle acc <= acc + pp_i, then i <= i+1, where
//   pp_i = b[i] ? (a << i) : 0, zero-extended to 2*WIDTH.
//   If the latched approx_en=1, pp_i &= ~((1<<APPROX_COLS)-1).
//   All WIDTH rows are always processed: there is no early exit for zero
//   operands.
//  Latency: out_valid rises exactly WIDTH cycles after the accept edge.
//  product = acc. It is registered and stays stable throughout DONE.
//  Width: acc is 2*WIDTH bits. The exact sum cannot overflow. The approx sum is
//   <= the exact sum, so it cannot overflow either.
//  Backpressure: while out_ready=0 in DONE, product and out_valid are held, and
//   in_ready stays 0.
//  Handoff: in_valid asserted during the out transfer cycle is not accepted.
//   Acceptance earliest one cycle later, once back in IDLE.
//  APPROX_COLS=0: approx mode gives bit-exact results.
// TESTING
//  WIDTH=8, a=13, b=11, approx_en=0, out_ready=1 -> product=143, out_valid 8 cycles after accept.
//  a=255, b=255, approx_en=0 -> product=65025; no overflow. Then a=0, b=200 -> product=0, still 8 cycles.
//  APPROX_COLS=4, a=15, b=15, approx_en=1 -> product=176 (rows 0,16,48,112); same operands exact -> 225.
//  Hold out_ready=0 for 5 cycles in DONE -> product/out_valid stable, in_ready=0; then one transfer, back to IDLE.
//  Assert rst during RUN (row 3) -> next cycle IDLE, in_ready=1, out_valid=0, product=0; new op 7*9 -> 63.
//  Change a/b/approx_en while busy -> result equals latched operands; back-to-back random ops vs golden model.

Source files
------------

// File: rtl/seq_array_mult.sv
`default_nettype none
// ============================================================================
//  Module      : seq_array_mult (with ha / fa cells)
//  Description : Iterative unsigned array multiplier. One partial-product row
//                is added into a 2*WIDTH accumulator per cycle through a
//                ripple row of ha/fa cells. An optional approximate mode
//                zeroes the low APPROX_COLS columns of every partial product.
//  Revision    : 1.0 - initial release
// ============================================================================

// Half adder cell
module ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

// Full adder cell
module fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module seq_array_mult #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
  // Keeps every column at or above APPROX_COLS; APPROX_COLS=0 keeps all.
  localparam logic [PW-1:0] c_mask = {PW{1'b1}} << APPROX_COLS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic            r_approx;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_row;

  logic [PW-1:0]   w_pp_raw;
  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_sum;
  logic [PW-2:0]   w_carry;
  logic            w_accept;
  logic            w_last_row;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_last_row = (r_row == c_last);

  // Current partial-product row, optionally truncated in approximate mode
  assign w_pp_raw = r_b[r_row] ? ({{WIDTH{1'b0}}, r_a} << r_row) : '0;
  assign w_pp     = r_approx ? (w_pp_raw & c_mask) : w_pp_raw;

  // Ripple adder row: acc + pp. The top carry is never needed because the
  // accumulated sum is bounded by the full 2*WIDTH-bit product.
  generate
    for (genvar k = 0; k < PW; k++) begin : g_bit
      if (k == 0) begin : g_lsb
        ha u_ha (
          .i_a (r_acc[k]),
          .i_b (w_pp[k]),
          .o_s (w_sum[k]),
          .o_c (w_carry[k])
        );
      end else if (k == PW - 1) begin : g_msb
        assign w_sum[k] = r_acc[k] ^ w_pp[k] ^ w_carry[k-1];
      end else begin : g_mid
        fa u_fa (
          .i_a (r_acc[k]),
          .i_b (w_pp[k]),
          .i_c (w_carry[k-1]),
          .o_s (w_sum[k]),
          .o_c (w_carry[k])
        );
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs decoded from the state
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last_row) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch on accept, one row accumulated per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_approx <= 1'b0;
      r_acc    <= '0;
      r_row    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_approx <= approx_en;
      r_acc    <= '0;
      r_row    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_sum;
      r_row <= w_last_row ? '0 : r_row + 1'b1;
    end
  end

  assign product = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_seq_array_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_array_mult
//  Description : Directed self-checking bench for seq_array_mult (WIDTH=8,
//                APPROX_COLS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_array_mult;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int passed = 0;
  int total  = 0;

  seq_array_mult #(.WIDTH(8), .APPROX_COLS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation; returns product and cycles from accept to out_valid.
  // Inputs are scrambled right after accept. If out_ready=1 the transfer
  // edge is consumed before returning.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tap, output logic [15:0] prod,
                       output int lat);
    @(negedge clk);
    a = ta; b = tb_; approx_en = tap; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = 8'($urandom_range(255));
    b         = 8'($urandom_range(255));
    approx_en = ~tap;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    prod = product;
    if (out_ready && lat > 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; approx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (product !== 16'd0) $display("FAIL reset_product got=%0d exp=0", product); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat;
    do_op(8'd13, 8'd11, 1'b0, p, lat);
    total++; if (p !== 16'd143) $display("FAIL basic_product got=%0d exp=143", p); else passed++;
    total++; if (lat !== 8) $display("FAIL basic_latency got=%0d exp=8", lat); else passed++;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL basic_idle_after in_ready=%b busy=%b exp=1/0", in_ready, busy); else passed++;
  endtask

  task automatic test_extremes();
    logic [15:0] p; int lat;
    do_op(8'd255, 8'd255, 1'b0, p, lat);
    total++; if (p !== 16'd65025) $display("FAIL max_product got=%0d exp=65025", p); else passed++;
    total++; if (lat !== 8) $display("FAIL max_latency got=%0d exp=8", lat); else passed++;
    do_op(8'd0, 8'd200, 1'b0, p, lat);
    total++; if (p !== 16'd0) $display("FAIL zero_product got=%0d exp=0", p); else passed++;
    total++; if (lat !== 8) $display("FAIL zero_latency got=%0d exp=8", lat); else passed++;
  endtask

  task automatic test_approx();
    logic [15:0] p; int lat;
    do_op(8'd15, 8'd15, 1'b1, p, lat);
    total++; if (p !== 16'd176) $display("FAIL approx_15x15 got=%0d exp=176", p); else passed++;
    do_op(8'd15, 8'd15, 1'b0, p, lat);
    total++; if (p !== 16'd225) $display("FAIL exact_15x15 got=%0d exp=225", p); else passed++;
  endtask

  task automatic test_backpressure();
    logic [15:0] p; int lat;
    out_ready = 1'b0;
    do_op(8'd9, 8'd9, 1'b0, p, lat);
    total++; if (p !== 16'd81) $display("FAIL bp_product got=%0d exp=81", p); else passed++;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || product !== 16'd81 || in_ready !== 1'b0)
        $display("FAIL bp_hold cyc=%0d out_valid=%b product=%0d in_ready=%b exp=1/81/0", k, out_valid, product, in_ready);
      else passed++;
    end
    // New operands offered during the transfer cycle must not be taken
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 8'd2; b = 8'd3; approx_en = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL handoff_idle out_valid=%b in_ready=%b busy=%b exp=0/1/0", out_valid, in_ready, busy);
    else passed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL handoff_accept busy=%b exp=1", busy); else passed++;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    total++; if (lat !== 8 || product !== 16'd6) $display("FAIL handoff_op lat=%0d product=%0d exp=8/6", lat, product); else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] p; int lat;
    @(negedge clk);
    a = 8'd100; b = 8'd100; approx_en = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'd0 || busy !== 1'b0)
      $display("FAIL midrst_async in_ready=%b out_valid=%b product=%0d busy=%b exp=1/0/0/0", in_ready, out_valid, product, busy);
    else passed++;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midrst_next in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); else passed++;
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd7, 8'd9, 1'b0, p, lat);
    total++; if (p !== 16'd63 || lat !== 8) $display("FAIL midrst_newop product=%0d lat=%0d exp=63/8", p, lat); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [6] = '{8'd200, 8'd3,   8'd128, 8'd255, 8'd16,  8'd1};
    logic [7:0]  vb [6] = '{8'd3,   8'd5,   8'd2,   8'd1,   8'd17,  8'd255};
    logic        vx [6] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1};
    logic [15:0] ve [6] = '{16'd600, 16'd15, 16'd256, 16'd240, 16'd272, 16'd240};
    logic [15:0] p; int lat;
    for (int k = 0; k < 6; k++) begin
      do_op(va[k], vb[k], vx[k], p, lat);
      total++;
      if (p !== ve[k] || lat !== 8)
        $display("FAIL b2b_%0d a=%0d b=%0d approx=%b product=%0d lat=%0d exp=%0d/8", k, va[k], vb[k], vx[k], p, lat, ve[k]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_approx();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
